clk_enable_gen: RTL and testbench

Parametrised, single-clock successor to the fixed 25 MHz clock wizard. It derives NUM_CH independent, runtime-programmable clock-enable strobes from one system clock using phase accumulators. Examples are the VGA pixel tick, the snake game tick and the input-debounce tick. It keeps all logic on one clock tree instead of spawning new clocks, and provides a `locked` status with a configurable settle period. It sits at the top of the design, between the board clock/reset and the VGA timing and game-logic blocks.

---
 rtl/clk_en_gen_pkg.sv | 19 +
 rtl/clk_en_gen_phase_acc.sv | 59 +++++
 rtl/clk_enable_gen.sv | 73 +++++++
 tb/tb_clk_enable_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
// Optional level outputs are enabled by defining CLK_EN_GEN_LEVEL_EN.
package clk_en_gen_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } fsm_state_e;

    localparam int ACC_W_DEF = 24;

    // Increment for a target strobe rate: (f_out * 2^acc_w) / f_clk, truncated.
    function automatic logic [63:0] calc_inc(input logic [63:0] f_out,
                                             input logic [63:0] f_clk,
                                             input int          acc_w);
        return (f_out << acc_w) / f_clk;
    endfunction

endpackage

// File: rtl/clk_en_gen_phase_acc.sv
// One strobe channel: increment register, phase accumulator, carry tick.
// With CLK_EN_GEN_LEVEL_EN the accumulator MSB is also registered out as a level.
module clk_en_phase_acc #(
    parameter int               ACC_W       = 24,
    parameter logic [ACC_W-1:0] DEFAULT_INC = {2'b01, {(ACC_W-2){1'b0}}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             inc_load_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             tick_o
`ifdef CLK_EN_GEN_LEVEL_EN
   ,output logic             level_o
`endif
);

    logic [ACC_W-1:0] inc_q, acc_q, acc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // Not running (unlocked, restart or disabled) pins the phase to zero.
    always_comb begin
        acc_d  = '0;
        tick_d = 1'b0;
        if (run_i) begin
            acc_d  = sum[ACC_W-1:0];
            tick_d = sum[ACC_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inc_q  <= DEFAULT_INC;
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            if (inc_load_i) inc_q <= inc_i;
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef CLK_EN_GEN_LEVEL_EN
    logic level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) level_q <= 1'b0;
        else         level_q <= acc_d[ACC_W-1];
    end

    assign level_o = level_q;
`endif

endmodule

// File: rtl/clk_enable_gen.sv
// NUM_CH runtime-programmable clock-enable strobes from one clock, with a settle/lock FSM.
// Define CLK_EN_GEN_LEVEL_EN to add the 50%-duty clk_level outputs.
module clk_enable_gen
    import clk_en_gen_pkg::*;
#(
    parameter int               NUM_CH      = 2,
    parameter int               ACC_W       = ACC_W_DEF,
    parameter int               LOCK_CYCLES = 1024,
    parameter logic [ACC_W-1:0] DEFAULT_INC = {2'b01, {(ACC_W-2){1'b0}}}
) (
    input  logic                    clk_in1,
    input  logic                    resetn,
    input  logic                    soft_rst,
    input  logic [NUM_CH*ACC_W-1:0] inc_in,
    input  logic                    inc_load,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       tick,
    output logic                    locked
`ifdef CLK_EN_GEN_LEVEL_EN
   ,output logic [NUM_CH-1:0]       clk_level
`endif
);

    localparam int               CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LOCK_CYCLES - 1);

    fsm_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             locked_q;
    logic [NUM_CH-1:0] run;

    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else if (soft_rst) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else if (state_q == SETTLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
            end
        end else begin
            locked_q <= 1'b1;
        end
    end

    assign locked = locked_q;
    // The lock edge itself still holds phase at 0, so the first carry lands 2^ACC_W/inc edges later.
    assign run    = {NUM_CH{locked_q & ~soft_rst}} & ch_en;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_en_phase_acc #(
            .ACC_W      (ACC_W),
            .DEFAULT_INC(DEFAULT_INC)
        ) u_acc (
            .clk_i     (clk_in1),
            .rst_ni    (resetn),
            .run_i     (run[k]),
            .inc_load_i(inc_load),
            .inc_i     (inc_in[k*ACC_W +: ACC_W]),
            .tick_o    (tick[k])
`ifdef CLK_EN_GEN_LEVEL_EN
           ,.level_o   (clk_level[k])
`endif
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomized self-checking bench for clk_enable_gen against a phase/period reference model.
// Checks clk_level too when CLK_EN_GEN_LEVEL_EN is defined.
module tb_clk_enable_gen;

    localparam int     NCH = 2;
    localparam int     W   = 24;
    localparam int     LC  = 16;
    localparam longint MOD = longint'(1) << W;
    localparam longint DEF = longint'(1) << (W - 2);

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               soft_rst = 1'b0;
    logic               inc_load = 1'b0;
    logic [NCH*W-1:0]   inc_in = '0;
    logic [NCH-1:0]     ch_en = '1;
    logic [NCH-1:0]     tick;
    logic               locked;
`ifdef CLK_EN_GEN_LEVEL_EN
    logic [NCH-1:0]     clk_level;
`endif

    clk_enable_gen #(
        .NUM_CH(NCH), .ACC_W(W), .LOCK_CYCLES(LC)
    ) dut (
        .clk_in1 (clk),
        .resetn  (resetn),
        .soft_rst(soft_rst),
        .inc_in  (inc_in),
        .inc_load(inc_load),
        .ch_en   (ch_en),
        .tick    (tick),
        .locked  (locked)
`ifdef CLK_EN_GEN_LEVEL_EN
       ,.clk_level(clk_level)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: edges since (re)start decide lock; phase is a plain integer mod 2^W.
    longint m_phase [NCH];
    longint m_inc   [NCH];
    bit     m_tick  [NCH];
    bit     m_lvl   [NCH];
    int     m_since;
    bit     m_locked;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_since  = 0;
        m_locked = 0;
        for (int k = 0; k < NCH; k++) begin
            m_phase[k] = 0; m_inc[k] = DEF; m_tick[k] = 0; m_lvl[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit was_locked;
        longint s;
        was_locked = m_locked;
        if (soft_rst) begin
            m_since = 0; m_locked = 0;
        end else if (!m_locked) begin
            m_since++;
            if (m_since == LC) m_locked = 1;
        end
        for (int k = 0; k < NCH; k++) begin
            if (soft_rst || !was_locked || !ch_en[k]) begin
                m_phase[k] = 0; m_tick[k] = 0;
            end else begin
                s = m_phase[k] + m_inc[k];
                m_tick[k]  = (s >= MOD);
                m_phase[k] = s % MOD;
            end
            m_lvl[k] = (m_phase[k] >= MOD / 2);
            if (inc_load) m_inc[k] = longint'(inc_in[k*W +: W]);
        end
    endtask

    task automatic compare_outputs();
        logic [NCH-1:0] et, el;
        for (int k = 0; k < NCH; k++) begin
            et[k] = m_tick[k]; el[k] = m_lvl[k];
        end
        chk("tick", 64'(tick), 64'(et));
        chk("locked", 64'(locked), 64'(m_locked));
`ifdef CLK_EN_GEN_LEVEL_EN
        chk("clk_level", 64'(clk_level), 64'(el));
`else
        if (el === 'x) $display("unreachable");
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic load(input logic [W-1:0] i0, input logic [W-1:0] i1, input bit srst);
        inc_in   = {i1, i0};
        inc_load = 1'b1;
        soft_rst = srst;
        step();
        inc_load = 1'b0;
        soft_rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_inc();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom_range(32'h010000, 32'h800000));
        endcase
    endfunction

    initial begin
        bit seen;
        int c_dut, c_mod;

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        resetn = 1'b1;

        // Lock after exactly LC edges, default increments give a 4-cycle strobe.
        seen = 0;
        for (int e = 1; e <= 24; e++) begin
            step();
            if (locked && !seen) begin
                seen = 1;
                chk("lock_edge", 64'(e), 64'(LC));
            end
        end
        if (!seen) chk("lock_seen", 64'd0, 64'd1);

        // Mid-run reload: ch0 to period 8, ch1 to ~25.
        load(24'h200000, 24'h0A3D70, 1'b0);
        repeat (40) step();

        c_dut = 0; c_mod = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            c_dut += int'(tick[1]);
            c_mod += int'(m_tick[1]);
        end
        chk("avg_ch1", 64'(c_dut), 64'(c_mod));
        chk("avg_ch1_range", 64'(c_dut >= 399 && c_dut <= 401), 64'd1);

        ch_en = 2'b01;
        repeat (5) step();
        ch_en = 2'b11;
        repeat (40) step();

        // Restart with new increments loaded on the same edge.
        load(24'h400000, 24'h100000, 1'b1);
        repeat (LC + 40) step();

        // Boundary increments: never ticks / ticks almost always.
        load(24'h000000, 24'hFFFFFF, 1'b0);
        repeat (60) step();

        for (int i = 0; i < 3000; i++) begin
            ch_en    = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '1;
            soft_rst = ($urandom_range(0, 299) == 0);
            inc_load = ($urandom_range(0, 19) == 0);
            inc_in   = {rnd_inc(), rnd_inc()};
            step();
        end
        soft_rst = 1'b0; inc_load = 1'b0; ch_en = '1;
        repeat (LC + 4) step();

        // Asynchronous reset in the middle of a strobe.
        load(24'h300000, 24'h123456, 1'b0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (tick[0]) seen = 1;
        end
        if (!seen) chk("strobe_wait", 64'd0, 64'd1);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_tick", 64'(tick), 64'd0);
        chk("async_locked", 64'(locked), 64'd0);
`ifdef CLK_EN_GEN_LEVEL_EN
        chk("async_level", 64'(clk_level), 64'd0);
`endif
        #2;
        resetn = 1'b1;
        repeat (LC + 30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
